// File: rtl/rsc2_dec_depunct.sv
// Duobit de-puncturer for one rsc2 parity stream (Y or W): rebuilds the full-rate soft
// stream, inserting zero-LLR erasures at punctured positions. Optional: RSC2_DEC_DEPUNCT_STAT_EN.
module rsc2_dec_depunct #(
  parameter int pWnY   = 0,
  parameter int pLLR_W = 5,
  parameter int pLEN_W = 13
) (
  input  logic                  iclk,
  input  logic                  ireset,
  input  logic                  iclkena,
  input  logic [3:0]            icode,
  input  logic [pLEN_W-1:0]     ilen,
  input  logic                  isop,
  input  logic                  ival,
  input  logic [2*pLLR_W-1:0]   idat,
  output logic                  ordy,
  output logic                  osop,
  output logic                  oeop,
  output logic                  oval,
  output logic [2*pLLR_W-1:0]   odat,
  output logic                  oerr
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
  ,
  output logic [pLEN_W-1:0]     oerase_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  // Transmit mask indexed by pattern phase; W carries data only at rate 1/3.
  function automatic logic [27:0] mask_f(input logic [2:0] c);
    logic [27:0] y;
    case (c)
      3'd0:    y = 28'h0000001;
      3'd1:    y = 28'h0000001;
      3'd2:    y = 28'h0000001;
      3'd3:    y = 28'h0000005;
      3'd4:    y = 28'h0000001;
      3'd5:    y = 28'h0011111;
      3'd6:    y = 28'h0000011;
      default: y = 28'h0101011;
    endcase
    if (pWnY != 0 && c != 3'd0) y = 28'h0;
    return y;
  endfunction

  // Last phase of the pattern period.
  function automatic logic [4:0] per_f(input logic [2:0] c);
    case (c)
      3'd0:    return 5'd0;
      3'd1:    return 5'd0;
      3'd2:    return 5'd1;
      3'd3:    return 5'd5;
      3'd4:    return 5'd3;
      3'd5:    return 5'd19;
      3'd6:    return 5'd11;
      default: return 5'd27;
    endcase
  endfunction

  state_t                state, nstate;
  logic [pLEN_W-1:0]     pos, npos, len_r, nlen;
  logic [2:0]            code_r, ncode;
  logic [4:0]            cnt, ncnt;
  logic                  nval, nsop, neop, nerr;
  logic [2*pLLR_W-1:0]   ndat;
  logic [27:0]           cur_mask;
  logic                  tx, acc, adv;
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
  logic [pLEN_W-1:0]     ecnt, necnt;
`endif

  assign cur_mask = mask_f(code_r);
  assign tx       = cur_mask[cnt];
  // Ready depends only on registered state so the upstream never sees a comb path from ival.
  assign ordy     = (state == IDLE) | tx;
  assign acc      = iclkena & ival & ordy;

  always_comb begin
    nstate = state;
    npos   = pos;
    nlen   = len_r;
    ncode  = code_r;
    ncnt   = cnt;
    nval   = oval;
    nsop   = osop;
    neop   = oeop;
    nerr   = oerr;
    ndat   = odat;
    adv    = 1'b0;
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
    necnt  = ecnt;
`endif
    if (iclkena) begin
      nval = 1'b0;
      nsop = 1'b0;
      neop = 1'b0;
      nerr = 1'b0;
      if (acc && isop) begin
        // New frame; a sop seen while running truncates the old frame.
        nerr  = (state == RUN);
        ncode = icode[2:0];
        nlen  = ilen;
        nval  = 1'b1;
        nsop  = 1'b1;
        ndat  = idat;
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
        necnt = '0;
`endif
        if (ilen == pLEN_W'(1)) begin
          neop   = 1'b1;
          nstate = IDLE;
          npos   = '0;
          ncnt   = '0;
        end else begin
          nstate = RUN;
          npos   = pLEN_W'(1);
          ncnt   = (per_f(icode[2:0]) != 5'd0) ? 5'd1 : 5'd0;
        end
      end else if (state == RUN) begin
        if (tx && ival) begin
          nval = 1'b1;
          ndat = idat;
          adv  = 1'b1;
        end else if (!tx) begin
          // Erasures never wait for input.
          nval = 1'b1;
          ndat = '0;
          adv  = 1'b1;
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
          necnt = ecnt + pLEN_W'(1);
`endif
        end
        if (adv) begin
          if (pos == len_r - pLEN_W'(1)) begin
            neop   = 1'b1;
            nstate = IDLE;
            npos   = '0;
            ncnt   = '0;
          end else begin
            npos = pos + pLEN_W'(1);
            ncnt = (cnt == per_f(code_r)) ? 5'd0 : cnt + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state  <= IDLE;
      pos    <= '0;
      len_r  <= '0;
      code_r <= '0;
      cnt    <= '0;
      oval   <= 1'b0;
      osop   <= 1'b0;
      oeop   <= 1'b0;
      oerr   <= 1'b0;
      odat   <= '0;
    end else begin
      state  <= nstate;
      pos    <= npos;
      len_r  <= nlen;
      code_r <= ncode;
      cnt    <= ncnt;
      oval   <= nval;
      osop   <= nsop;
      oeop   <= neop;
      oerr   <= nerr;
      odat   <= ndat;
    end
  end

`ifdef RSC2_DEC_DEPUNCT_STAT_EN
  always_ff @(posedge iclk) begin
    if (ireset) ecnt <= '0;
    else        ecnt <= necnt;
  end
  assign oerase_cnt = ecnt;
`endif

endmodule

// File: tb/tb_rsc2_dec_depunct.sv
// Bench for rsc2_dec_depunct: Y and W instances driven together, checked each cycle
// against a position-modulo puncturing model, plus directed stream checks.
module tb_rsc2_dec_depunct;
  localparam int LW = 5, NW = 13, DW = 2*LW;

  logic iclk = 1'b0;
  logic ireset, iclkena, isop, ival;
  logic [3:0]    icode;
  logic [NW-1:0] ilen;
  logic [DW-1:0] idat;
  logic [1:0]    ordy, osop, oeop, oval, oerr;
  logic [DW-1:0] odat [2];
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
  logic [NW-1:0] ecnt [2];
`endif

  always #5 iclk = ~iclk;

  rsc2_dec_depunct #(.pWnY(0), .pLLR_W(LW), .pLEN_W(NW)) dut_y (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .icode(icode), .ilen(ilen),
    .isop(isop), .ival(ival), .idat(idat), .ordy(ordy[0]), .osop(osop[0]),
    .oeop(oeop[0]), .oval(oval[0]), .odat(odat[0]), .oerr(oerr[0])
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
    , .oerase_cnt(ecnt[0])
`endif
  );

  rsc2_dec_depunct #(.pWnY(1), .pLLR_W(LW), .pLEN_W(NW)) dut_w (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .icode(icode), .ilen(ilen),
    .isop(isop), .ival(ival), .idat(idat), .ordy(ordy[1]), .osop(osop[1]),
    .oeop(oeop[1]), .oval(oval[1]), .odat(odat[1]), .oerr(oerr[1])
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
    , .oerase_cnt(ecnt[1])
`endif
  );

  int checks = 0, failures = 0;
  // model state per instance
  bit mact [2];
  int mpos [2], mn [2], mcode [2], mec [2];
  bit ev [2], es [2], ee [2], er [2];
  logic [DW-1:0] ed [2];
  bit acc0;
  int lowcnt, acc1cnt, eopcnt, errcnt;
  logic [DW-1:0] capy [$];
  logic [DW-1:0] capw [$];

  // Position k carries data iff k==0 or the pattern bit at phase k mod (s+1) is set.
  function automatic bit tx(int w, int c, int k);
    int p;
    if (k == 0) return 1'b1;
    if (c == 0) return 1'b1;
    if (c == 1) return (w == 0);
    if (w != 0) return 1'b0;
    case (c)
      2: begin p = k % 2;  return p == 0; end
      3: begin p = k % 6;  return p == 0 || p == 2; end
      4: begin p = k % 4;  return p == 0; end
      5: begin p = k % 20; return (p % 4) == 0; end
      6: begin p = k % 12; return p == 0 || p == 4; end
      default: begin p = k % 28; return p == 0 || p == 4 || p == 12 || p == 20; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit rdy, acc, t;
    for (int i = 0; i < 2; i++) begin
      rdy = !mact[i] || tx(i, mcode[i], mpos[i]);
      chk($sformatf("ordy%0d", i), {31'b0, ordy[i]}, {31'b0, rdy});
      acc = iclkena && ival && rdy;
      if (i == 0) begin acc0 = acc; if (!rdy) lowcnt++; end
      if (i == 1 && acc && !ireset) acc1cnt++;
      if (ireset) begin
        mact[i] = 0; mpos[i] = 0; mec[i] = 0;
        ev[i] = 0; es[i] = 0; ee[i] = 0; er[i] = 0; ed[i] = '0;
      end else if (iclkena) begin
        ev[i] = 0; es[i] = 0; ee[i] = 0; er[i] = 0;
        if (acc && isop) begin
          er[i] = mact[i]; mcode[i] = int'(icode[2:0]); mn[i] = int'(ilen);
          ev[i] = 1; es[i] = 1; ed[i] = idat; mec[i] = 0;
          if (mn[i] == 1) begin ee[i] = 1; mact[i] = 0; mpos[i] = 0; end
          else begin mact[i] = 1; mpos[i] = 1; end
        end else if (mact[i]) begin
          t = tx(i, mcode[i], mpos[i]);
          if (t && ival) begin ev[i] = 1; ed[i] = idat; end
          else if (!t) begin ev[i] = 1; ed[i] = '0; mec[i]++; end
          if (ev[i]) begin
            if (mpos[i] == mn[i] - 1) begin ee[i] = 1; mact[i] = 0; mpos[i] = 0; end
            else mpos[i]++;
          end
        end
      end
    end
    @(posedge iclk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("oval%0d", i), {31'b0, oval[i]}, {31'b0, ev[i]});
      chk($sformatf("osop%0d", i), {31'b0, osop[i]}, {31'b0, es[i]});
      chk($sformatf("oeop%0d", i), {31'b0, oeop[i]}, {31'b0, ee[i]});
      chk($sformatf("oerr%0d", i), {31'b0, oerr[i]}, {31'b0, er[i]});
      if (ev[i] || ireset) chk($sformatf("odat%0d", i), 32'(odat[i]), 32'(ed[i]));
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
      chk($sformatf("ecnt%0d", i), 32'(ecnt[i]), 32'(mec[i]));
`endif
    end
    if (oval[0] && iclkena) capy.push_back(odat[0]);
    if (oval[1] && iclkena) capw.push_back(odat[1]);
    if (oval[0] && oeop[0] && iclkena) eopcnt++;
    if (oerr[0] && iclkena) errcnt++;
  endtask

  // pval: ival probability in percent, or 200 for alternating ival.
  task automatic frame(input int code, input int n, input int pval, input int pena,
                       input int trunc_at, input int rst_at);
    bit started = 0, truncd = 0, rstdone = 0, was;
    int c;
    icode = 4'(code); ilen = NW'(n);
    capy.delete(); capw.delete();
    lowcnt = 0; acc1cnt = 0; eopcnt = 0; errcnt = 0;
    for (c = 0; c < 3000; c++) begin
      iclkena = ($urandom_range(99) < pena);
      isop = !started;
      ival = (pval == 200) ? c[0] : ($urandom_range(99) < pval);
      if (isop) ival = 1'b1;
      idat = DW'($urandom) | DW'(1);
      if (trunc_at >= 0 && started && !truncd && mact[0] && mpos[0] >= trunc_at) begin
        isop = 1'b1; ival = 1'b1;
      end
      if (rst_at >= 0 && started && !rstdone && mact[0] && mpos[0] == rst_at) begin
        ireset = 1'b1; iclkena = 1'b0; rstdone = 1;
      end
      was = started;
      cyc();
      ireset = 1'b0;
      if (acc0 && isop) begin if (was) truncd = 1; started = 1; end
      if (started && !mact[0] && !mact[1]) break;
    end
    checks++;
    assert (c < 3000) else begin
      failures++;
      $error("FAIL timeout observed=%0d expected=<3000", c);
    end
    isop = 1'b0; ival = 1'b0;
  endtask

  initial begin
    int z3 [8] = '{0, 1, 0, 1, 1, 1, 0, 1};
    int z4 [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    ireset = 1'b1; iclkena = 1'b1; isop = 1'b0; ival = 1'b0; idat = '0;
    icode = '0; ilen = NW'(1);
    for (int i = 0; i < 2; i++) begin
      mact[i] = 0; mpos[i] = 0; mn[i] = 1; mcode[i] = 0; mec[i] = 0;
      ev[i] = 0; es[i] = 0; ee[i] = 0; er[i] = 0; ed[i] = '0;
    end
    repeat (2) @(posedge iclk);
    #1;
    cyc();
    ireset = 1'b0;
    cyc();

    // rate 1/2, back-to-back
    frame(1, 4, 100, 100, -1, -1);
    chk("r12_len", capy.size(), 4);
    chk("r12_ordy_low", lowcnt, 0);

    // rate 3/4, erasure layout
    frame(3, 8, 100, 100, -1, -1);
    chk("r34_len", capy.size(), 8);
    for (int k = 0; k < 8 && k < capy.size(); k++)
      chk($sformatf("r34_pos%0d", k), {31'b0, capy[k] == '0}, 32'(z3[k]));
    chk("r34_ordy_low", lowcnt, 5);
`ifdef RSC2_DEC_DEPUNCT_STAT_EN
    chk("r34_ecnt", 32'(ecnt[0]), 5);
`endif

    // rate 4/5 with gapped input
    frame(4, 9, 200, 100, -1, -1);
    chk("r45_len", capy.size(), 9);
    for (int k = 0; k < 9 && k < capy.size(); k++)
      chk($sformatf("r45_pos%0d", k), {31'b0, capy[k] == '0}, 32'(z4[k]));

    // W stream, rate 2/3
    frame(2, 3, 100, 100, -1, -1);
    chk("w23_len", capw.size(), 3);
    if (capw.size() == 3) begin
      chk("w23_p0", {31'b0, capw[0] == '0}, 0);
      chk("w23_p1", 32'(capw[1]), 0);
      chk("w23_p2", 32'(capw[2]), 0);
    end
    chk("w23_consumed", acc1cnt, 1);

    // truncation by mid-frame sop
    frame(3, 8, 100, 100, 4, -1);
    chk("trunc_err", errcnt, 1);
    chk("trunc_eop", eopcnt, 1);

    // reset mid-frame with clock enable low, then a clean frame
    frame(3, 8, 100, 100, -1, 3);
    chk("rst_eop", eopcnt, 0);
    frame(3, 8, 100, 100, -1, -1);
    chk("after_rst_len", capy.size(), 8);

    // single-position frame
    frame(5, 1, 100, 100, -1, -1);
    chk("n1_len", capy.size(), 1);

    // randomized frames
    for (int f = 0; f < 30; f++)
      frame($urandom_range(7), $urandom_range(40, 1), $urandom_range(100, 30),
            $urandom_range(100, 60), -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
